// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V constants and the BTB entry layout for the default configuration.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam int BTB_ENTRIES  = 16;
   localparam int BTB_IDX      = $clog2(BTB_ENTRIES);
   localparam int BTB_TAG_W    = XLEN - BTB_IDX - 2;
   localparam int BTB_CNT_BITS = 2;

   typedef struct packed {
      logic                    valid;
      logic [BTB_TAG_W-1:0]    tag;
      logic [XLEN-1:0]         target;
      logic [BTB_CNT_BITS-1:0] ctr;
   } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: next-value logic for a saturating counter with load, set-to-max, increment and decrement.
module sat_counter #(
   parameter int CNT_BITS = 2
) (
   input  logic [CNT_BITS-1:0] i_ctr,
   input  logic                i_inc,
   input  logic                i_dec,
   input  logic                i_set_max,
   input  logic                i_load,
   input  logic [CNT_BITS-1:0] i_load_val,
   output logic [CNT_BITS-1:0] o_ctr
);

   localparam logic [CNT_BITS-1:0] MAX = {CNT_BITS{1'b1}};

   always_comb
      o_ctr = i_load                        ? i_load_val :
              i_set_max                     ? MAX :
              (i_inc && i_ctr != MAX)       ? i_ctr + CNT_BITS'(1) :
              (i_dec && i_ctr != '0)        ? i_ctr - CNT_BITS'(1) :
                                              i_ctr;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating counters; IF-stage lookup,
// EX-stage training, misprediction detection and branch statistics.
module branch_predictor
   import riscv_pkg::*;
#(
   parameter int WIDTH    = XLEN,
   parameter int ENTRIES  = 16,
   parameter int CNT_BITS = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_pc_f,
   output logic             o_predict_taken_f,
   output logic [WIDTH-1:0] o_predict_target_f,
   input  logic             i_ex_valid,
   input  logic             i_ex_branch,
   input  logic             i_ex_jump,
   input  logic [WIDTH-1:0] i_ex_pc,
   input  logic             i_ex_taken,
   input  logic [WIDTH-1:0] i_ex_target,
   input  logic             i_ex_pred_taken,
   input  logic [WIDTH-1:0] i_ex_pred_target,
   output logic             o_mispredict_e,
   output logic [WIDTH-1:0] o_redirect_pc_e,
   input  logic             i_stats_clear,
   output logic [WIDTH-1:0] o_branch_count,
   output logic [WIDTH-1:0] o_mispredict_count
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = WIDTH - IDX - 2;
   localparam logic [CNT_BITS-1:0] CTR_MAX = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0] CTR_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
   localparam logic [CNT_BITS-1:0] CTR_WNT = CTR_WT - CNT_BITS'(1);

   logic                r_valid  [ENTRIES];
   logic [TAG_W-1:0]    r_tag    [ENTRIES];
   logic [WIDTH-1:0]    r_target [ENTRIES];
   logic [CNT_BITS-1:0] r_ctr    [ENTRIES];
   logic [WIDTH-1:0]    r_branch_count;
   logic [WIDTH-1:0]    r_mispredict_count;

   logic [IDX-1:0]      w_idx_f, w_idx_e;
   logic [TAG_W-1:0]    w_tag_f, w_tag_e;
   logic                w_hit_f, w_hit_e, w_cf, w_train, w_alias, w_alloc;
   logic [CNT_BITS-1:0] w_ctr_next;

   assign w_idx_f = i_pc_f[IDX+1:2];
   assign w_tag_f = i_pc_f[WIDTH-1:IDX+2];
   assign w_idx_e = i_ex_pc[IDX+1:2];
   assign w_tag_e = i_ex_pc[WIDTH-1:IDX+2];

   assign w_hit_f = r_valid[w_idx_f] && r_tag[w_idx_f] == w_tag_f;
   assign w_hit_e = r_valid[w_idx_e] && r_tag[w_idx_e] == w_tag_e;

   assign o_predict_taken_f  = w_hit_f && r_ctr[w_idx_f][CNT_BITS-1];
   assign o_predict_target_f = o_predict_taken_f ? r_target[w_idx_f] : i_pc_f + WIDTH'(4);

   assign w_cf    = i_ex_branch || i_ex_jump;
   assign w_train = i_ex_valid && w_cf;
   assign w_alias = i_ex_valid && !w_cf && i_ex_pred_taken;
   // a hit always rewrites its entry; a miss allocates only when taken
   assign w_alloc = w_train && (w_hit_e || i_ex_taken);

   assign o_mispredict_e = i_ex_valid &&
      ((w_cf && (i_ex_taken != i_ex_pred_taken || (i_ex_taken && i_ex_target != i_ex_pred_target))) ||
       (!w_cf && i_ex_pred_taken));
   assign o_redirect_pc_e = (i_ex_taken && w_cf) ? i_ex_target : i_ex_pc + WIDTH'(4);

   sat_counter #(.CNT_BITS(CNT_BITS)) u_ctr (
      .i_ctr      (r_ctr[w_idx_e]),
      .i_inc      (i_ex_taken),
      .i_dec      (!i_ex_taken),
      .i_set_max  (i_ex_jump),
      .i_load     (!w_hit_e),
      .i_load_val (i_ex_jump ? CTR_MAX : CTR_WT),
      .o_ctr      (w_ctr_next)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= CTR_WNT;
         end
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else begin
         if (w_alloc) begin
            r_valid[w_idx_e] <= 1'b1;
            r_tag[w_idx_e]   <= w_tag_e;
            r_ctr[w_idx_e]   <= w_ctr_next;
         end
         if (w_train && i_ex_taken)
            r_target[w_idx_e] <= i_ex_target;
         if (w_alias && w_hit_e)
            r_valid[w_idx_e] <= 1'b0;
         r_branch_count     <= i_stats_clear ? '0 : r_branch_count + WIDTH'(w_train);
         r_mispredict_count <= i_stats_clear ? '0 : r_mispredict_count + WIDTH'(o_mispredict_e);
      end
   end

   assign o_branch_count     = r_branch_count;
   assign o_mispredict_count = r_mispredict_count;

endmodule
